// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC output path.
// Stats counters are enabled with the AUDIO_DAC_STATS_EN macro.
package audio_pkg;
  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} dac_state_t;

  localparam int AUDIO_W        = 32;
  localparam int STATS_W        = 16;
  localparam int I2S_DELAY_BITS = 1;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/audio_sample_fifo.sv
// Stereo-pair sample FIFO: push/pop/clear with occupancy level.
// Clear wins over a same-cycle push or pop.
module audio_sample_fifo #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push_ok, w_pop_ok;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LW'(w_push_ok) - LW'(w_pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !clear) r_mem[r_wr_ptr] <= din;
  end
endmodule

// File: rtl/audio_dac_serializer.sv
// I2S-style DAC serializer fed from a stereo sample FIFO, timed by codec BCLK/LRCK.
// Define AUDIO_DAC_STATS_EN for live underrun/overflow saturating counters.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter  int SAMPLE_W    = 32,
  parameter  int FIFO_DEPTH  = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  input  logic [AUDIO_W-1:0] left_channel_audio_out,
  input  logic [AUDIO_W-1:0] right_channel_audio_out,
  input  logic               write_audio_out,
  input  logic               clear_audio_out_memory,
  input  logic               AUD_BCLK,
  input  logic               AUD_DACLRCK,
  output logic               audio_out_allowed,
  output logic [LW-1:0]      fifo_level,
  output logic               underrun,
  output logic               AUD_DACDAT,
  output logic [STATS_W-1:0] underrun_count,
  output logic [STATS_W-1:0] overflow_count
);
  localparam int CW = $clog2(SAMPLE_W + 1);

  logic [SYNC_STAGES-1:0] r_bclk_sync, r_lr_sync;
  logic                   w_bclk_fall, w_lr_fall, w_lr_rise;
  dac_state_t             r_state, w_state_nxt;
  logic                   w_pop, w_load_l, w_load_r, w_underrun;
  logic                   r_ready, r_underrun, r_dacdat;
  logic                   w_full, w_empty, w_push;
  logic [2*AUDIO_W-1:0]   w_fifo_dout;
  logic [SAMPLE_W-1:0]    r_shifter, r_hold_r;
  logic [CW-1:0]          r_bit_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], AUD_DACLRCK};
      r_ready     <= 1'b1;
    end
  end

  assign w_bclk_fall = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_sync[SYNC_STAGES-2];
  assign w_lr_fall   = r_lr_sync[SYNC_STAGES-1] & ~r_lr_sync[SYNC_STAGES-2];
  assign w_lr_rise   = ~r_lr_sync[SYNC_STAGES-1] & r_lr_sync[SYNC_STAGES-2];

  assign audio_out_allowed = r_ready & ~w_full;
  assign w_push            = write_audio_out & audio_out_allowed;

  audio_sample_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(2*AUDIO_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .push  (w_push),
    .pop   (w_pop),
    .clear (clear_audio_out_memory),
    .din   ({left_channel_audio_out, right_channel_audio_out}),
    .dout  (w_fifo_dout),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= ALIGN;
    else          r_state <= w_state_nxt;
  end

  // A frame only ever starts on lr_fall, so ALIGN never emits a partial right slot.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_l    = 1'b0;
    w_load_r    = 1'b0;
    w_underrun  = 1'b0;
    if (w_lr_fall) begin
      w_load_l    = 1'b1;
      w_pop       = ~w_empty;
      w_underrun  = w_empty;
      w_state_nxt = LEFT;
    end else if (w_lr_rise && r_state == LEFT) begin
      w_load_r    = 1'b1;
      w_state_nxt = RIGHT;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_shifter  <= '0;
      r_hold_r   <= '0;
      r_bit_cnt  <= '0;
      r_dacdat   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_underrun;
      if (w_load_l) begin
        r_shifter <= w_pop ? w_fifo_dout[AUDIO_W +: SAMPLE_W] : '0;
        r_hold_r  <= w_pop ? w_fifo_dout[0 +: SAMPLE_W] : '0;
        r_bit_cnt <= '0;
        r_dacdat  <= 1'b0;
      end else if (w_load_r) begin
        r_shifter <= r_hold_r;
        r_bit_cnt <= '0;
        r_dacdat  <= 1'b0;
      end else if (w_bclk_fall && r_state != ALIGN) begin
        if (r_bit_cnt < CW'(SAMPLE_W)) begin
          r_dacdat  <= r_shifter[SAMPLE_W-1];
          r_shifter <= r_shifter << 1;
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end else begin
          r_dacdat <= 1'b0;
        end
      end
    end
  end

  assign AUD_DACDAT = r_dacdat;
  assign underrun   = r_underrun;

`ifdef AUDIO_DAC_STATS_EN
  logic [STATS_W-1:0] r_underrun_cnt, r_overflow_cnt;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_underrun_cnt <= '0;
      r_overflow_cnt <= '0;
    end else begin
      if (w_underrun)                r_underrun_cnt <= sat_inc(r_underrun_cnt);
      if (write_audio_out && w_full) r_overflow_cnt <= sat_inc(r_overflow_cnt);
    end
  end

  assign underrun_count = r_underrun_cnt;
  assign overflow_count = r_overflow_cnt;
`else
  assign underrun_count = '0;
  assign overflow_count = '0;
`endif
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: FIFO table, I2S bit model, reset corner cases.
// Checks stats counters when AUDIO_DAC_STATS_EN is defined.
module tb_audio_dac_serializer;
  localparam int SW    = 32;
  localparam int DEPTH = 8;
  localparam int HP    = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic [31:0] l_in = '0, r_in = '0;
  logic        wr = 1'b0, clr = 1'b0, bclk = 1'b1, lrck = 1'b1;
  logic        allowed, underrun, dacdat;
  logic [3:0]  level;
  logic [15:0] und_cnt, ovf_cnt;

  audio_dac_serializer dut (
    .CLOCK_50                (CLOCK_50),
    .reset_n                 (reset_n),
    .left_channel_audio_out  (l_in),
    .right_channel_audio_out (r_in),
    .write_audio_out         (wr),
    .clear_audio_out_memory  (clr),
    .AUD_BCLK                (bclk),
    .AUD_DACLRCK             (lrck),
    .audio_out_allowed       (allowed),
    .fifo_level              (level),
    .underrun                (underrun),
    .AUD_DACDAT              (dacdat),
    .underrun_count          (und_cnt),
    .overflow_count          (ovf_cnt)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0, n_bad = 0;
  int und_seen = 0;
  int exp_und_total = 0, exp_und_stat = 0, exp_ovf = 0;
  logic [63:0] q[$];

  always @(posedge CLOCK_50) if (underrun === 1'b1) und_seen++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check_stats();
`ifdef AUDIO_DAC_STATS_EN
    check("underrun_count", {16'd0, und_cnt}, exp_und_stat);
    check("overflow_count", {16'd0, ovf_cnt}, exp_ovf);
`else
    check("underrun_count_off", {16'd0, und_cnt}, 32'd0);
    check("overflow_count_off", {16'd0, ovf_cnt}, 32'd0);
`endif
  endtask

  // One bit-clock period; LRCK changes with the falling BCLK, DAC data sampled before the rise.
  task automatic bclk_cycle(input logic lr, input logic exp, input string nm);
    bclk = 1'b0;
    lrck = lr;
    clk_n(HP);
    check(nm, {31'd0, dacdat}, {31'd0, exp});
    bclk = 1'b1;
    clk_n(HP);
  endtask

  // Reference: slot bit j is 0 for the delay slot, then sample MSB-first, then zeros.
  function automatic logic slot_bit(input logic [31:0] s, input int j);
    if (j == 0 || j > SW) return 1'b0;
    return s[SW-j];
  endfunction

  task automatic run_frames(input int n, input int half);
    logic [63:0] pair;
    logic [31:0] s;
    for (int f = 0; f < n; f++) begin
      if (q.size() > 0) pair = q.pop_front();
      else begin
        pair = '0;
        exp_und_total++;
        exp_und_stat++;
      end
      for (int ch = 0; ch < 2; ch++) begin
        s = (ch == 0) ? pair[63:32] : pair[31:0];
        for (int j = 0; j < half; j++) bclk_cycle(ch[0], slot_bit(s, j), ch == 0 ? "left_bit" : "right_bit");
        if (ch == 0) check("underrun_pulses", und_seen, exp_und_total);
      end
    end
  endtask

  task automatic write_cycle(input logic [31:0] l, input logic [31:0] r, input logic c);
    l_in = l;
    r_in = r;
    wr   = 1'b1;
    clr  = c;
    if (q.size() == DEPTH) exp_ovf++;
    if (c) q.delete();
    else if (q.size() < DEPTH) q.push_back({l, r});
    clk_n(1);
    wr  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    reset_n = 1'b0;
    #1;
    check("rst_dacdat", {31'd0, dacdat}, 32'd0);
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_allowed", {31'd0, allowed}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    clk_n(cycles);
    reset_n = 1'b1;
    q.delete();
    exp_und_stat = 0;
    exp_ovf = 0;
    clk_n(2);
    check("allowed_after_rst", {31'd0, allowed}, 32'd1);
  endtask

  typedef struct {
    int   n_wr;
    bit   do_clr;
    bit   clr_wr;
    int   exp_level;
    logic exp_allowed;
  } fifo_vec_t;

  fifo_vec_t vecs[7];

  initial begin
    vecs[0] = '{3, 0, 0, 3, 1'b1};
    vecs[1] = '{0, 1, 1, 0, 1'b1};
    vecs[2] = '{8, 0, 0, 8, 1'b0};
    vecs[3] = '{3, 0, 0, 8, 1'b0};
    vecs[4] = '{0, 1, 0, 0, 1'b1};
    vecs[5] = '{3, 0, 0, 3, 1'b1};
    vecs[6] = '{0, 1, 1, 0, 1'b1};

    clk_n(3);
    apply_reset(3);
    check_stats();

    // Known-pattern frame
    write_cycle(32'h80000001, 32'h7FFFFFFE, 1'b0);
    check("level_one", {28'd0, level}, 32'd1);
    run_frames(1, 34);

    // No data: zeros and one underrun per left frame
    run_frames(2, 34);
    check_stats();

    // FIFO fill/overflow/clear table with LRCK stopped
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n_wr; k++) write_cycle($urandom, $urandom, 1'b0);
      if (vecs[i].do_clr) begin
        if (vecs[i].clr_wr) write_cycle($urandom, $urandom, 1'b1);
        else begin
          clr = 1'b1;
          q.delete();
          clk_n(1);
          clr = 1'b0;
        end
      end
      check("tbl_level", {28'd0, level}, vecs[i].exp_level);
      check("tbl_allowed", {31'd0, allowed}, {31'd0, vecs[i].exp_allowed});
      check("tbl_model_level", {28'd0, level}, q.size());
      check_stats();
    end
    run_frames(1, 34);

    // Randomized rounds, one with a 32-BCLK slot that truncates the LSB
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) write_cycle($urandom, $urandom, 1'b0);
      check("rand_level", {28'd0, level}, q.size());
      run_frames(n + 1, (r == 2) ? 32 : 34);
    end
    check_stats();

    // Reset released mid right frame: silent until the first lr_fall
    bclk = 1'b1;
    lrck = 1'b1;
    apply_reset(3);
    write_cycle(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
    for (int j = 0; j < 5; j++) bclk_cycle(1'b1, 1'b0, "align_quiet");
    run_frames(1, 34);

    // Reset mid left frame: frame aborted, re-align at the next lr_fall
    write_cycle(32'hC3C3C3C3, 32'h3C3C3C3C, 1'b0);
    write_cycle(32'h12345678, 32'h9ABCDEF0, 1'b0);
    for (int j = 0; j < 10; j++) bclk_cycle(1'b0, slot_bit(32'hC3C3C3C3, j), "pre_abort_bit");
    apply_reset(3);
    for (int j = 10; j < 34; j++) bclk_cycle(1'b0, 1'b0, "abort_left_quiet");
    for (int j = 0; j < 34; j++) bclk_cycle(1'b1, 1'b0, "abort_right_quiet");
    check("abort_no_underrun", und_seen, exp_und_total);
    write_cycle(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0);
    run_frames(2, 34);
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
